// File: rtl/game2048_pkg.sv
// Shared constants and state types for the 2048 input stage.
package game2048_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {SC_IDLE, SC_E0, SC_F0, SC_E0F0} sc_state_t;

  // Returns {is_arrow, direction} for an extended scan code.
  function automatic logic [2:0] decode_arrow(input logic [7:0] code);
    case (code)
      SC_UP:    return {1'b1, DIR_UP};
      SC_DOWN:  return {1'b1, DIR_DOWN};
      SC_LEFT:  return {1'b1, DIR_LEFT};
      SC_RIGHT: return {1'b1, DIR_RIGHT};
      default:  return {1'b0, 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: input synchronisers, clock glitch filter, frame FSM
// with odd-parity/stop checking and an in-frame idle timeout.
module ps2_rx
  import game2048_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       start,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_r, dat_sync_r;
  logic          clk_filt_r, strobe_r;
  logic [FW-1:0] filt_cnt_r;
  rx_state_t     state_r;
  logic [7:0]    shift_r;
  logic [2:0]    bit_cnt_r;
  logic          parity_ok_r;
  logic [TW-1:0] tout_cnt_r;

  // Two-flop synchronisers; idle bus level is high.
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      clk_sync_r <= 2'b11;
      dat_sync_r <= 2'b11;
    end else begin
      clk_sync_r <= {clk_sync_r[0], ps2_clk};
      dat_sync_r <= {dat_sync_r[0], ps2_dat};
    end
  end

  // Glitch filter; strobe fires when the filtered clock falls.
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      clk_filt_r <= 1'b1;
      filt_cnt_r <= '0;
      strobe_r   <= 1'b0;
    end else if (clk_sync_r[1] == clk_filt_r) begin
      filt_cnt_r <= '0;
      strobe_r   <= 1'b0;
    end else if (filt_cnt_r == FW'(FILTER_CYCLES - 1)) begin
      clk_filt_r <= clk_sync_r[1];
      filt_cnt_r <= '0;
      strobe_r   <= clk_filt_r;
    end else begin
      filt_cnt_r <= filt_cnt_r + FW'(1);
      strobe_r   <= 1'b0;
    end
  end

  // Frame FSM with timeout that only runs while a frame is open.
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      state_r     <= RX_IDLE;
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      parity_ok_r <= 1'b0;
      tout_cnt_r  <= '0;
      rx_byte     <= 8'h00;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (strobe_r) begin
        tout_cnt_r <= '0;
        case (state_r)
          RX_IDLE: begin
            if (!dat_sync_r[1]) begin
              state_r   <= RX_DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          RX_DATA: begin
            shift_r   <= {dat_sync_r[1], shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) state_r <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_ok_r <= ^{shift_r, dat_sync_r[1]};
            state_r     <= RX_STOP;
          end
          RX_STOP: begin
            if (dat_sync_r[1] && parity_ok_r) begin
              rx_byte    <= shift_r;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state_r <= RX_IDLE;
          end
          default: state_r <= RX_IDLE;
        endcase
      end else if (state_r == RX_IDLE) begin
        tout_cnt_r <= '0;
      end else if (tout_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err  <= 1'b1;
        state_r    <= RX_IDLE;
        tout_cnt_r <= '0;
      end else begin
        tout_cnt_r <= tout_cnt_r + TW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard to 2048 command decoder: arrow moves via valid/ready,
// 's' as a start pulse, typematic repeats suppressed by held flags.
module ps2_keypad
  import game2048_pkg::*;
#(
  parameter int         FILTER_CYCLES  = 8,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] KEY_S          = 8'h1B
) (
  input  logic       clock,
  input  logic       start,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       dir_ready,
  output logic [1:0] direction,
  output logic       dir_valid,
  output logic       start_key,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic [2:0] arrow_s;
  sc_state_t  sc_state_r;
  logic       s_held_r;
  logic [3:0] arrow_held_r;

  ps2_rx #(
    .FILTER_CYCLES (FILTER_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock     (clock),
    .start     (start),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign arrow_s = decode_arrow(rx_byte);

  // Scan decoder, held flags and direction handshake.
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      sc_state_r   <= SC_IDLE;
      s_held_r     <= 1'b0;
      arrow_held_r <= 4'b0000;
      direction    <= 2'b00;
      dir_valid    <= 1'b0;
      start_key    <= 1'b0;
    end else begin
      start_key <= 1'b0;
      if (dir_valid && dir_ready) dir_valid <= 1'b0;
      // A lost byte breaks any prefix sequence, so restart decoding.
      if (frame_err) begin
        sc_state_r <= SC_IDLE;
      end else if (byte_valid) begin
        case (sc_state_r)
          SC_IDLE: begin
            if (rx_byte == SC_EXT) begin
              sc_state_r <= SC_E0;
            end else if (rx_byte == SC_BRK) begin
              sc_state_r <= SC_F0;
            end else if (rx_byte == KEY_S && !s_held_r) begin
              start_key <= 1'b1;
              s_held_r  <= 1'b1;
            end
          end
          SC_E0: begin
            sc_state_r <= SC_IDLE;
            if (rx_byte == SC_BRK) begin
              sc_state_r <= SC_E0F0;
            end else if (arrow_s[2] && !arrow_held_r[arrow_s[1:0]]) begin
              arrow_held_r[arrow_s[1:0]] <= 1'b1;
              if (!dir_valid) begin
                direction <= arrow_s[1:0];
                dir_valid <= 1'b1;
              end
            end
          end
          SC_F0: begin
            if (rx_byte == KEY_S) s_held_r <= 1'b0;
            sc_state_r <= SC_IDLE;
          end
          SC_E0F0: begin
            if (arrow_s[2]) arrow_held_r[arrow_s[1:0]] <= 1'b0;
            sc_state_r <= SC_IDLE;
          end
          default: sc_state_r <= SC_IDLE;
        endcase
      end
    end
  end

endmodule
